// File: rtl/guess_input_cond.sv
// Input conditioner for the guessing game: synchronises the raw active-low
// pushbutton and slide switches, debounces the button, and produces one
// single-cycle enter pulse per physical press with the switch value captured
// on that same edge.
module guess_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned W               = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_n,
  input  logic [W-1:0] sw,
  output logic         enter,
  output logic [W-1:0] guess
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StHeld        = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  logic         key_meta_q, key_s_q;
  logic [W-1:0] sw_meta_q, sw_s_q;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            enter_q, enter_d;
  logic [W-1:0]    guess_q, guess_d;

  // Two-flop synchronisers; the key chain idles released (high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
    end
  end

  // Debounce FSM: a level must hold for DEBOUNCE_CYCLES samples to be accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter_d = 1'b0;
    guess_d = guess_q;
    case (state_q)
      StIdle: begin
        if (!key_s_q) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (key_s_q) begin
          // Press bounce: fall back without a pulse.
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StHeld;
          enter_d = 1'b1;
          guess_d = sw_s_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (key_s_q) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (!key_s_q) begin
          // Release bounce: still considered held, so no new pulse.
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      guess_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
      guess_q <= guess_d;
    end
  end

  assign enter = enter_q;
  assign guess = guess_q;

endmodule

// File: tb/tb_guess_input_cond.sv
// Directed bench for guess_input_cond with DEBOUNCE_CYCLES=4. A behavioural
// model tracks the accepted button level and run length of disagreeing samples;
// outputs are compared every cycle, plus literal pulse timing/value checks.
module tb_guess_input_cond;

  localparam int unsigned D = 4;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_n;
  logic [W-1:0] sw;
  logic         enter;
  logic [W-1:0] guess;

  guess_input_cond #(
    .DEBOUNCE_CYCLES(D),
    .W              (W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .sw   (sw),
    .enter(enter),
    .guess(guess)
  );

  always #10 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int edge_no    = 0;
  int pulses     = 0;
  int last_pulse = -1;

  // Model state: accepted level (pressed), run of disagreeing samples, and
  // two-deep input history standing in for the synchroniser delay.
  logic         m_enter = 1'b0;
  logic [W-1:0] m_guess = '0;
  bit           m_pressed = 1'b0;
  int           m_run = 0;
  logic         kh0 = 1'b1, kh1 = 1'b1;
  logic [W-1:0] sh0 = '0, sh1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_no++;
  end

  // Behavioural model.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_enter = 1'b0; m_guess = '0; m_pressed = 1'b0; m_run = 0;
      kh0 = 1'b1; kh1 = 1'b1; sh0 = '0; sh1 = '0;
    end else begin
      bit disagree;
      m_enter  = 1'b0;
      disagree = m_pressed ? (kh1 == 1'b1) : (kh1 == 1'b0);
      if (disagree) begin
        m_run++;
        if (m_run == D + 1) begin
          m_pressed = !m_pressed;
          m_run     = 0;
          if (m_pressed) begin
            m_enter = 1'b1;
            m_guess = sh1;
          end
        end
      end else begin
        m_run = 0;
      end
      kh1 = kh0; kh0 = key_n;
      sh1 = sh0; sh0 = sw;
    end
  end

  // Per-cycle compare and pulse bookkeeping, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("cyc_enter", 32'(enter), 32'(m_enter));
      check("cyc_guess", 32'(guess), 32'(m_guess));
      if (enter === 1'b1) begin
        pulses++;
        last_pulse = edge_no;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, base;
    logic [W-1:0] vals [3];
    vals[0] = 8'h10; vals[1] = 8'h08; vals[2] = 8'h0C;

    reset = 1'b1; key_n = 1'b1; sw = '0;
    tick(3);
    check("rst_enter", 32'(enter), 32'd0);
    check("rst_guess", 32'(guess), 32'd0);
    reset = 1'b0;
    tick(5);

    // 1: clean press, pulse after edge 7.
    p0 = pulses; base = edge_no;
    sw = 8'h10; key_n = 1'b0;
    tick(20);
    check("t1_count", 32'(pulses - p0), 32'd1);
    check("t1_edge", 32'(last_pulse - base), 32'd7);
    check("t1_guess", 32'(guess), 32'h10);
    key_n = 1'b1;
    tick(10);

    // 2: bounce, final fall at offset 7 -> pulse at offset 14.
    p0 = pulses; base = edge_no;
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(13);
    check("t2_count", 32'(pulses - p0), 32'd1);
    check("t2_edge", 32'(last_pulse - base), 32'd14);
    key_n = 1'b1;
    tick(10);

    // 3: long hold, release with a re-low glitch.
    p0 = pulses;
    sw = 8'h5A; key_n = 1'b0; tick(100);
    key_n = 1'b1; tick(3);
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(20);
    check("t3_count", 32'(pulses - p0), 32'd1);
    check("t3_guess", 32'(guess), 32'h5A);

    // 4: switch changes while held are ignored until the next press.
    sw = 8'h08; key_n = 1'b0; tick(12);
    sw = 8'hFF; tick(10);
    check("t4_held", 32'(guess), 32'h08);
    key_n = 1'b1; tick(12);
    check("t4_released", 32'(guess), 32'h08);
    key_n = 1'b0; tick(12);
    check("t4_repress", 32'(guess), 32'hFF);
    key_n = 1'b1; tick(10);

    // 5: reset during PRESS_WAIT with cnt=2.
    sw = 8'h33; key_n = 1'b0;
    tick(5);
    reset = 1'b1; key_n = 1'b1;
    #1;
    check("t5_rst_enter", 32'(enter), 32'd0);
    check("t5_rst_guess", 32'(guess), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(6);
    p0 = pulses; base = edge_no;
    key_n = 1'b0; tick(12);
    check("t5_count", 32'(pulses - p0), 32'd1);
    check("t5_edge", 32'(last_pulse - base), 32'd7);
    check("t5_guess", 32'(guess), 32'h33);
    key_n = 1'b1; tick(10);

    // 6: three clean presses with distinct switch values.
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      sw = vals[i]; key_n = 1'b0; tick(12);
      check("t6_guess", 32'(guess), 32'(vals[i]));
      key_n = 1'b1; tick(10);
    end
    check("t6_count", 32'(pulses - p0), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
